// File: rtl/pwm_compare.sv
// pwm_compare: glitch-free PWM compare stage fed by a free-running counter.
// Duty writes are double-buffered and only applied at the detected period start.
module pwm_compare #(
   parameter int CNT_WIDTH = 8
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [CNT_WIDTH-1:0] i_count,
   input  logic                 i_enable,
   input  logic [CNT_WIDTH:0]   i_duty,
   input  logic                 i_duty_valid,
   output logic                 o_duty_ready,
   output logic                 o_pwm,
   output logic                 o_period_start,
   output logic [CNT_WIDTH:0]   o_active_duty
);

   localparam logic [CNT_WIDTH:0] DUTY_MAX = {1'b1, {CNT_WIDTH{1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [CNT_WIDTH-1:0] r_prev;
   logic [CNT_WIDTH:0]   r_pend;
   logic [CNT_WIDTH:0]   r_active;
   logic [CNT_WIDTH:0]   r_active_next;
   logic                 r_pend_full;
   logic                 ps;
   logic                 accept;
   logic                 pend_load;
   logic                 cmp_high;
   logic                 pwm_next;

   function automatic logic [CNT_WIDTH:0] clamp_duty(input logic [CNT_WIDTH:0] duty);
      return (duty > DUTY_MAX) ? DUTY_MAX : duty;
   endfunction

   // A held-at-zero counter yields a single start because r_prev follows it to zero.
   assign ps        = (i_count == '0) && (r_prev != '0);
   assign accept    = i_duty_valid && !r_pend_full;
   assign pend_load = accept && !ps;

   always_comb begin
      r_active_next = r_active;
      if (ps && r_pend_full) begin
         r_active_next = r_pend;
      end else if (ps && accept) begin
         r_active_next = clamp_duty(i_duty);
      end
   end

   // Compare against the duty being loaded this cycle so a new value starts at count 0.
   assign cmp_high = ({1'b0, i_count} < r_active_next);

   always_comb begin
      state_next = state;
      pwm_next   = 1'b0;
      if (!i_enable) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               state_next = ARMED;
            end
            ARMED: begin
               if (ps) begin
                  state_next = RUN;
                  pwm_next   = cmp_high;
               end
            end
            RUN: begin
               pwm_next = cmp_high;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // Output stage: one cycle after the count sample.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state          <= IDLE;
         r_prev         <= '1;
         r_pend_full    <= 1'b0;
         r_active       <= '0;
         o_pwm          <= 1'b0;
         o_period_start <= 1'b0;
      end else begin
         state          <= state_next;
         r_prev         <= i_count;
         r_active       <= r_active_next;
         o_pwm          <= pwm_next;
         o_period_start <= ps;
         if (pend_load) begin
            r_pend_full <= 1'b1;
         end else if (ps) begin
            r_pend_full <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (pend_load) begin
         r_pend <= clamp_duty(i_duty);
      end
   end

   assign o_duty_ready  = !r_pend_full;
   assign o_active_duty = r_active;

endmodule

// File: tb/tb_pwm_compare.sv
// tb_pwm_compare: directed vector table plus hand-written running-counter
// sequences for pwm_compare with CNT_WIDTH = 8.
module tb_pwm_compare;

   localparam int CW = 8;

   typedef struct {
      logic [CW-1:0] c;
      logic          e;
      logic [CW:0]   d;
      logic          v;
      logic          pwm;
      logic          ps;
      logic          rdy;
      logic [CW:0]   act;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [CW-1:0] count;
   logic          en;
   logic [CW:0]   duty;
   logic          valid;
   logic          ready;
   logic          pwm;
   logic          ps;
   logic [CW:0]   active;

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [CW-1:0] cnt;
   logic [CW-1:0] last;
   vec_t          tbl[24];

   always #5 clk = ~clk;

   pwm_compare #(.CNT_WIDTH(CW)) dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_count       (count),
      .i_enable      (en),
      .i_duty        (duty),
      .i_duty_valid  (valid),
      .o_duty_ready  (ready),
      .o_pwm         (pwm),
      .o_period_start(ps),
      .o_active_duty (active)
   );

   function automatic vec_t mk(input int c, input int e, input int d, input int v,
                               input int p, input int s, input int r, input int a);
      vec_t t;
      t.c   = 8'(c);
      t.e   = 1'(e);
      t.d   = 9'(d);
      t.v   = 1'(v);
      t.pwm = 1'(p);
      t.ps  = 1'(s);
      t.rdy = 1'(r);
      t.act = 9'(a);
      return t;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input logic [CW-1:0] c);
      count = c;
      @(posedge clk);
      #1;
      last = c;
   endtask

   task automatic tick_run();
      tick(cnt);
      cnt = cnt + 8'd1;
   endtask

   // Runs the counter until the given count has been applied; returns pwm-high samples.
   task automatic run_until(input logic [CW-1:0] target, input string name, output int highs);
      bit found = 1'b0;
      highs = 0;
      for (int i = 0; i < 300; i++) begin
         tick_run();
         highs += int'(pwm);
         if (last == target) begin
            found = 1'b1;
            break;
         end
      end
      chk({name, "_reached"}, int'(found), 1);
   endtask

   // Runs n counter steps; returns high samples, period starts and pattern errors for duty d.
   task automatic run_n(input int n, input int d, output int highs, output int psc, output int errs);
      highs = 0;
      psc   = 0;
      errs  = 0;
      for (int i = 0; i < n; i++) begin
         tick_run();
         highs += int'(pwm);
         psc   += int'(ps);
         if (int'(pwm) != int'(int'(last) < d)) errs++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      int highs, psc, errs, lows;

      // count, enable, duty, valid | pwm, ps, ready, active
      tbl[0]  = mk(3,   0, 64,  1,  0, 0, 0, 0);
      tbl[1]  = mk(4,   1, 0,   0,  0, 0, 0, 0);
      tbl[2]  = mk(0,   1, 0,   0,  1, 1, 1, 64);
      tbl[3]  = mk(63,  1, 0,   0,  1, 0, 1, 64);
      tbl[4]  = mk(64,  1, 0,   0,  0, 0, 1, 64);
      tbl[5]  = mk(100, 1, 200, 1,  0, 0, 0, 64);
      tbl[6]  = mk(10,  1, 17,  1,  1, 0, 0, 64);
      tbl[7]  = mk(0,   1, 0,   0,  1, 1, 1, 200);
      tbl[8]  = mk(199, 1, 0,   0,  1, 0, 1, 200);
      tbl[9]  = mk(200, 1, 0,   0,  0, 0, 1, 200);
      tbl[10] = mk(0,   1, 300, 1,  1, 1, 1, 256);
      tbl[11] = mk(255, 1, 0,   0,  1, 0, 1, 256);
      tbl[12] = mk(0,   1, 0,   0,  1, 1, 1, 256);
      tbl[13] = mk(5,   1, 0,   1,  1, 0, 0, 256);
      tbl[14] = mk(0,   1, 0,   0,  0, 1, 1, 0);
      tbl[15] = mk(128, 1, 0,   0,  0, 0, 1, 0);
      tbl[16] = mk(0,   0, 0,   0,  0, 1, 1, 0);
      tbl[17] = mk(7,   1, 0,   0,  0, 0, 1, 0);
      tbl[18] = mk(0,   1, 10,  1,  1, 1, 1, 10);
      tbl[19] = mk(9,   1, 0,   0,  1, 0, 1, 10);
      tbl[20] = mk(10,  1, 0,   0,  0, 0, 1, 10);
      tbl[21] = mk(0,   1, 0,   0,  1, 1, 1, 10);
      tbl[22] = mk(0,   1, 0,   0,  1, 0, 1, 10);
      tbl[23] = mk(0,   1, 0,   0,  1, 0, 1, 10);

      rst   = 1'b1;
      en    = 1'b1;
      duty  = 9'd50;
      valid = 1'b1;
      cnt   = 8'd0;
      last  = 8'd0;
      count = 8'd0;

      // Reset held for 5 cycles with the counter running and requests active.
      for (int i = 0; i < 5; i++) begin
         tick_run();
         chk("reset_pwm", int'(pwm), 0);
         chk("reset_ps", int'(ps), 0);
         chk("reset_ready", int'(ready), 1);
         chk("reset_active", int'(active), 0);
      end
      rst   = 1'b0;
      valid = 1'b0;
      en    = 1'b0;

      for (int i = 0; i < 24; i++) begin
         en    = tbl[i].e;
         duty  = tbl[i].d;
         valid = tbl[i].v;
         tick(tbl[i].c);
         chk($sformatf("vec%0d_pwm", i), int'(pwm), int'(tbl[i].pwm));
         chk($sformatf("vec%0d_ps", i), int'(ps), int'(tbl[i].ps));
         chk($sformatf("vec%0d_ready", i), int'(ready), int'(tbl[i].rdy));
         chk($sformatf("vec%0d_active", i), int'(active), int'(tbl[i].act));
      end

      // Reset mid-operation discards a pending duty.
      en    = 1'b1;
      valid = 1'b1;
      duty  = 9'd99;
      tick(8'd3);
      valid = 1'b0;
      chk("midrst_ready_before", int'(ready), 0);
      rst = 1'b1;
      #1;
      chk("midrst_async_ready", int'(ready), 1);
      chk("midrst_async_active", int'(active), 0);
      chk("midrst_async_pwm", int'(pwm), 0);
      tick(8'd4);
      rst = 1'b0;
      en  = 1'b0;
      tick(8'd0);
      chk("midrst_ps_after", int'(ps), 1);
      chk("midrst_pend_discarded", int'(active), 0);
      chk("midrst_ready_after", int'(ready), 1);

      // Basic duty 64 written while idle, then enabled.
      cnt   = 8'd1;
      valid = 1'b1;
      duty  = 9'd64;
      tick_run();
      valid = 1'b0;
      chk("basic_ready_low", int'(ready), 0);
      en = 1'b1;
      run_until(8'd0, "basic_wrap", highs);
      chk("basic_low_until_wrap", highs, 1);
      chk("basic_first_ps", int'(ps), 1);
      chk("basic_active", int'(active), 64);
      chk("basic_ready_back", int'(ready), 1);
      run_n(511, 64, highs, psc, errs);
      chk("basic_highs_2periods", highs + 1, 128);
      chk("basic_ps_2periods", psc + 1, 2);
      chk("basic_pattern", errs, 0);

      // Glitch-free update: 200 written at count 100, a second write refused.
      run_n(100, 64, highs, psc, errs);
      valid = 1'b1;
      duty  = 9'd200;
      tick_run();
      chk("upd_ready_drop", int'(ready), 0);
      duty = 9'd17;
      tick_run();
      valid = 1'b0;
      chk("upd_ready_full", int'(ready), 0);
      run_n(154, 64, highs, psc, errs);
      chk("upd_old_duty_kept", errs, 0);
      chk("upd_active_old", int'(active), 64);
      tick_run();
      chk("upd_wrap_ps", int'(ps), 1);
      chk("upd_wrap_active", int'(active), 200);
      chk("upd_wrap_ready", int'(ready), 1);
      run_n(255, 200, highs, psc, errs);
      chk("upd_highs", highs + 1, 200);
      tick_run();
      chk("upd_refused_not_applied", int'(active), 200);

      // Duty 300 clamps to 256: constant high across the wrap.
      valid = 1'b1;
      duty  = 9'd300;
      tick_run();
      valid = 1'b0;
      run_until(8'd0, "full_wrap", highs);
      chk("full_active_clamped", int'(active), 256);
      run_n(300, 256, highs, psc, errs);
      lows = 300 - highs;
      chk("full_no_lows", lows, 0);
      chk("full_ps_seen", psc, 1);

      // Duty 0: constant low.
      valid = 1'b1;
      duty  = 9'd0;
      tick_run();
      valid = 1'b0;
      run_until(8'd0, "zero_wrap", highs);
      chk("zero_active", int'(active), 0);
      chk("zero_pwm_at_wrap", int'(pwm), 0);
      run_n(300, 0, highs, psc, errs);
      chk("zero_no_highs", highs, 0);

      // Bypass: write presented exactly at count 0 with the slot empty.
      run_until(8'd255, "byp_pre", highs);
      valid = 1'b1;
      duty  = 9'd10;
      tick_run();
      valid = 1'b0;
      chk("byp_active", int'(active), 10);
      chk("byp_ready", int'(ready), 1);
      chk("byp_ps", int'(ps), 1);
      run_n(255, 10, highs, psc, errs);
      chk("byp_highs", highs + 1, 10);
      chk("byp_pattern", errs, 0);

      // Upstream counter held in reset for 11 cycles at count 50, duty 128.
      valid = 1'b1;
      duty  = 9'd128;
      tick_run();
      valid = 1'b0;
      run_until(8'd0, "crst_wrap", highs);
      chk("crst_active", int'(active), 128);
      run_until(8'd50, "crst_at50", highs);
      highs = 0;
      psc   = 0;
      for (int i = 0; i < 11; i++) begin
         tick(8'd0);
         highs += int'(pwm);
         psc   += int'(ps);
      end
      chk("crst_one_ps", psc, 1);
      chk("crst_high_hold", highs, 11);
      cnt = 8'd1;
      run_n(256, 128, highs, psc, errs);
      chk("crst_normal_pattern", errs, 0);
      chk("crst_normal_highs", highs, 128);
      chk("crst_normal_ps", psc, 1);

      // Disable at count 30, re-enable later: waits for the next wrap.
      run_until(8'd29, "dis_pre", highs);
      en = 1'b0;
      tick_run();
      chk("dis_pwm_low", int'(pwm), 0);
      run_until(8'd39, "dis_hold", highs);
      chk("dis_hold_low", highs, 0);
      en = 1'b1;
      run_until(8'd0, "dis_rearm", highs);
      chk("dis_low_until_wrap", highs, 1);
      chk("dis_wrap_pwm", int'(pwm), 1);
      chk("dis_wrap_ps", int'(ps), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pwm_compare.md
# pwm_compare

Downstream consumer of the free-running `Counter` output. Compares the counter value against a double-buffered duty register to produce one PWM output. The output is glitch-free: duty updates arrive over a valid/ready handshake and take effect only at the counter wrap (period start). A run/arm state machine guarantees that the first pulse after enable is a full period.

## Interface
- `CNT_WIDTH`, default 8: width of the counter input. The PWM period is 2^CNT_WIDTH counter steps.
- `i_clk`  in  1  clock, shared with the upstream counter.
- `i_reset`  in  1  reset; asynchronous, active-high. Clock is `i_clk`.
- `i_count`  in  CNT_WIDTH  counter value, taken from `o_out` of the upstream counter.
- `i_enable`  in  1  run request (level).
- `i_duty`  in  CNT_WIDTH+1  requested high-time in counter steps. Valid range 0..2^CNT_WIDTH.
- `i_duty_valid`  in  1  duty write request.
- `o_duty_ready`  out  1  pending slot empty; a write is accepted when valid and ready are both high.
- `o_pwm`  out  1  PWM output, registered.
- `o_period_start`  out  1  one-cycle pulse, registered, marking each detected period start.
- `o_active_duty`  out  CNT_WIDTH+1  duty value currently applied.

## Operation
- **Period-start detect (`ps`):** `ps = (i_count == 0) && (r_prev != 0)`.
  - `r_prev` is a register of `i_count`. It resets to all-ones, so a count of 0 right after reset is a start.
  - If the counter is held in reset (count stuck at 0), exactly one `ps` is produced.
- **Duty buffering:**
  - `r_pend` and `r_pend_full` hold one pending duty value. `o_duty_ready = !r_pend_full`.
  - On a handshake without `ps`, `r_pend <= i_duty` and `r_pend_full <= 1`.
  - On `ps` with `r_pend_full`, `r_active <= r_pend` and `r_pend_full <= 0`. Ready is 0 that cycle, so no write can collide.
  - On `ps` with the slot empty and a handshake in the same cycle, `r_active <= i_duty` directly (bypass) and `r_pend_full` stays 0.
  - Duty loads occur on `ps` in every state, including IDLE.
- **Duty range:** `i_duty` values above 2^CNT_WIDTH are clamped to 2^CNT_WIDTH when written into `r_pend` or `r_active`.
- **State machine (2-bit):**
  - IDLE: `o_pwm` = 0. Moves to ARMED when `i_enable` = 1.
  - ARMED: `o_pwm` = 0. Moves to RUN on `ps`; if `ps` coincides with the transition, the compare applies in that same cycle.
  - RUN: `o_pwm <= (i_count < r_active_next)`.
    - `r_active_next` is the value `r_active` takes this cycle, so the new duty applies starting at count 0.
    - The compare is zero-extended to CNT_WIDTH+1 bits.
    - Duty 0 gives a constant low output; duty 2^CNT_WIDTH gives a constant high output.
  - From any state, `i_enable` = 0 forces IDLE at the next edge, with `o_pwm` = 0 from that edge. The pending value is kept.
- **Reset values:**
  - Outputs: `o_pwm` = 0, `o_period_start` = 0, `o_duty_ready` = 1, `o_active_duty` = 0.
  - Internal: state IDLE, `r_pend_full` = 0, `r_prev` = all-ones.
- **Reset mid-operation:** asynchronous clear of all of the above. Any pending duty is discarded.

## Timing
- `o_pwm` and `o_period_start` have 1 cycle of latency from the `i_count` sample: a count sampled at edge N is reflected in the outputs after edge N+1.
- `o_active_duty` updates at the same edge as the first `o_pwm` computed with it.
- `o_duty_ready` falls at the edge following acceptance. It rises at the edge where a pending value is promoted to active.
- With the counter running every cycle and CNT_WIDTH=8:
  - the period is 256 cycles;
  - `o_pwm` is high for exactly `duty` consecutive cycles starting 1 cycle after count 0 is presented.
- Upstream counter reset of length L:
  - one `o_period_start`;
  - `o_pwm` holds the duty>0 level for L cycles;
  - normal operation resumes when the count leaves 0.

## Test plan
- **Reset:** assert `i_reset` for 5 cycles with the counter running. All outputs match their reset values, and `o_duty_ready` = 1 throughout.
- **Basic duty:** write duty=64 while IDLE, then enable. `o_pwm` = 0 until the first wrap, then 64 high and 192 low cycles per period. `o_period_start` pulses every 256 cycles.
- **Glitch-free update:**
  - With duty=64 running, write 200 at count 100. `o_duty_ready` drops to 0, `o_pwm` stays on 64 for the rest of the period, and 200 takes effect from the next count 0.
  - A second write while the slot is full is refused: it is not accepted and the pending value is unchanged.
- **Extremes:**
  - Duty 0 gives constant low.
  - Duty 256 gives constant high across the wrap.
  - Duty 300 reads back as 256 on `o_active_duty`.
- **Bypass collision:** with the slot empty, present duty=10 with valid exactly in the cycle count=0. `o_active_duty` = 10 on the next edge, the period is 10 high cycles, and `o_duty_ready` stays 1.
- **Counter reset mid-period:** hold the upstream counter reset for 11 cycles at count 50 with duty=128. Exactly one `o_period_start` occurs, `o_pwm` is high for 11 cycles, and then a normal period follows.
- **Disable:** deassert `i_enable` at count 30. `o_pwm` = 0 from the next edge; on re-enable, the block waits for the next wrap before driving the output.
